// File: rtl/mult_div_seq_unit.sv
// Iterative radix-2 multiply/divide unit with a one-entry result cache.
// Multiply uses shift-add and divide uses restoring steps, both on the magnitudes of the operands.
module mult_div_seq_unit #(
  parameter int PARALLELISM  = 32,
  parameter int OPCODE_WIDTH = 3,
  parameter int CACHE_EN     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [PARALLELISM-1:0]  operand0,
  input  logic [PARALLELISM-1:0]  operand1,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PARALLELISM-1:0]  result,
  output logic                    div_by_zero,
  output logic                    overflow_div,
  output logic                    overflow_mult,
  output logic                    cache_hit,
  output logic                    busy
);
  localparam int W  = PARALLELISM;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_SPECIAL, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  function automatic logic [2:0] op_class(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: op_class = 3'd0;
      3'b010:         op_class = 3'd1;
      3'b011:         op_class = 3'd2;
      3'b100, 3'b110: op_class = 3'd4;
      default:        op_class = 3'd5;
    endcase
  endfunction

  function automatic logic op0_signed(input logic [2:0] op);
    return !(op[0] && (op[1] || op[2]));
  endfunction

  function automatic logic op1_signed(input logic [2:0] op);
    return op[2] ? !op[0] : !op[1];
  endfunction

  function automatic logic [W-1:0] neg_w(input logic n, input logic [W-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic n, input logic [2*W-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  // Signed classes: high word must equal sign-extension of the low word.
  function automatic logic mult_ovf(input logic [2:0] op, input logic [2*W-1:0] full);
    if (op == 3'b011) return |full[2*W-1:W];
    return full[2*W-1:W] != {W{full[W-1]}};
  endfunction

  // Full results are held as {high/remainder, low/quotient}.
  function automatic logic [W-1:0] sel_word(input logic [2:0] op, input logic [2*W-1:0] full);
    if (op == 3'b000 || op == 3'b100 || op == 3'b101) return full[W-1:0];
    return full[2*W-1:W];
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fix_ph_q, fix_ph_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, dvsr_q, dvsr_d;
  logic [2*W-1:0] acc_q, acc_d, res_q, res_d;
  logic           neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic           dz_q, dz_d, ovd_q, ovd_d, ovm_q, ovm_d, hit_q, hit_d;
  logic           cache_vld_q, cache_vld_d, cache_ovm_q, cache_ovm_d;
  logic [2:0]     cache_cls_q, cache_cls_d;
  logic [W-1:0]   cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [2*W-1:0] cache_res_q, cache_res_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic [W-1:0]   result_q, result_d;
  logic           div_by_zero_q, div_by_zero_d, overflow_div_q, overflow_div_d;
  logic           overflow_mult_q, overflow_mult_d, cache_hit_q, cache_hit_d;

  logic [W:0]     mul_sum, rem_sh, rem_diff;
  logic           rem_ge, s0, s1, in_div0, in_ovfd, in_hit;
  logic [2*W-1:0] fix_full;

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dvsr_q} : '0);
  assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign rem_diff = rem_sh - {1'b0, dvsr_q};
  assign rem_ge   = rem_sh >= {1'b0, dvsr_q};
  assign s0       = op0_signed(op_q) && a_q[W-1];
  assign s1       = op1_signed(op_q) && b_q[W-1];
  assign fix_full = op_q[2] ? {neg_w(neg_hi_q, acc_q[2*W-1:W]), neg_w(neg_lo_q, acc_q[W-1:0])}
                            : neg_2w(neg_lo_q, acc_q);
  assign in_div0  = opCode[2] && (operand0 == '0);
  assign in_ovfd  = (opCode == 3'b100 || opCode == 3'b110) && operand1 == MIN_VAL && operand0 == '1;
  assign in_hit   = (CACHE_EN != 0) && cache_vld_q && cache_cls_q == op_class(opCode)
                    && cache_a_q == operand0 && cache_b_q == operand1;

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  fix_ph_d = fix_ph_q;
    op_d = op_q;  a_d = a_q;  b_d = b_q;  dvsr_d = dvsr_q;  acc_d = acc_q;  res_d = res_q;
    neg_lo_d = neg_lo_q;  neg_hi_d = neg_hi_q;
    dz_d = dz_q;  ovd_d = ovd_q;  ovm_d = ovm_q;  hit_d = hit_q;
    cache_vld_d = cache_vld_q;  cache_cls_d = cache_cls_q;  cache_a_d = cache_a_q;
    cache_b_d = cache_b_q;  cache_res_d = cache_res_q;  cache_ovm_d = cache_ovm_q;
    result_d = result_q;  div_by_zero_d = div_by_zero_q;  overflow_div_d = overflow_div_q;
    overflow_mult_d = overflow_mult_q;  cache_hit_d = cache_hit_q;
    if (state_q != S_IDLE && flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_d = opCode;  a_d = operand0;  b_d = operand1;
          dz_d = 1'b0;  ovd_d = 1'b0;  ovm_d = 1'b0;  hit_d = 1'b0;
          state_d = S_SPECIAL;
          if (in_div0) begin
            res_d = {operand1, {W{1'b1}}};  dz_d = 1'b1;
          end else if (in_ovfd) begin
            res_d = {{W{1'b0}}, MIN_VAL};  ovd_d = 1'b1;
          end else if (in_hit) begin
            res_d = cache_res_q;  ovm_d = cache_ovm_q;  hit_d = 1'b1;
          end else begin
            state_d = S_PREP;
          end
        end
        S_SPECIAL: state_d = S_DONE;
        S_PREP: begin
          dvsr_d   = neg_w(s0, a_q);
          acc_d    = {{W{1'b0}}, neg_w(s1, b_q)};
          neg_lo_d = s0 ^ s1;
          neg_hi_d = op_q[2] ? s1 : (s0 ^ s1);
          cnt_d    = '0;
          state_d  = S_CALC;
        end
        S_CALC: begin
          if (op_q[2]) acc_d = {rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0], acc_q[W-2:0], rem_ge};
          else         acc_d = {mul_sum, acc_q[W-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            fix_ph_d = 1'b0;
            state_d  = S_FIX;
          end
        end
        // Sign fix-up is registered first; the cache is written from the registered result.
        S_FIX: if (!fix_ph_q) begin
          res_d    = fix_full;
          ovm_d    = op_q[2] ? 1'b0 : mult_ovf(op_q, fix_full);
          fix_ph_d = 1'b1;
        end else begin
          cache_vld_d = 1'b1;  cache_cls_d = op_class(op_q);  cache_a_d = a_q;
          cache_b_d = b_q;  cache_res_d = res_q;  cache_ovm_d = ovm_q;
          state_d = S_DONE;
        end
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_DONE && state_q != S_DONE) begin
      result_d = sel_word(op_q, res_q);  div_by_zero_d = dz_q;  overflow_div_d = ovd_q;
      overflow_mult_d = ovm_q;  cache_hit_d = hit_q;
    end
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = !in_ready_d;
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  cnt_q <= '0;  fix_ph_q <= 1'b0;  cache_vld_q <= 1'b0;
      in_ready_q <= 1'b1;  out_valid_q <= 1'b0;  busy_q <= 1'b0;  result_q <= '0;
      div_by_zero_q <= 1'b0;  overflow_div_q <= 1'b0;  overflow_mult_q <= 1'b0;  cache_hit_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  fix_ph_q <= fix_ph_d;  cache_vld_q <= cache_vld_d;
      in_ready_q <= in_ready_d;  out_valid_q <= out_valid_d;  busy_q <= busy_d;  result_q <= result_d;
      div_by_zero_q <= div_by_zero_d;  overflow_div_q <= overflow_div_d;
      overflow_mult_q <= overflow_mult_d;  cache_hit_q <= cache_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;  a_q <= a_d;  b_q <= b_d;  dvsr_q <= dvsr_d;  acc_q <= acc_d;  res_q <= res_d;
    neg_lo_q <= neg_lo_d;  neg_hi_q <= neg_hi_d;
    dz_q <= dz_d;  ovd_q <= ovd_d;  ovm_q <= ovm_d;  hit_q <= hit_d;
    cache_cls_q <= cache_cls_d;  cache_a_q <= cache_a_d;  cache_b_q <= cache_b_d;
    cache_res_q <= cache_res_d;  cache_ovm_q <= cache_ovm_d;
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
  assign result        = result_q;
  assign div_by_zero   = div_by_zero_q;
  assign overflow_div  = overflow_div_q;
  assign overflow_mult = overflow_mult_q;
  assign cache_hit     = cache_hit_q;
endmodule

// File: tb/tb_mult_div_seq_unit.sv
// Bench for mult_div_seq_unit: directed vector table, hand-written corner sequences,
// then random operations checked against a 64-bit arithmetic reference with a model cache.
module tb_mult_div_seq_unit;
  localparam int W        = 32;
  localparam int LAT_IT   = W + 3;
  localparam int CACHE_EN = 1;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic div_by_zero, overflow_div, overflow_mult, cache_hit, busy;
  logic [2:0]   opCode;
  logic [W-1:0] operand0, operand1, result;

  int total = 0;
  int bad   = 0;

  bit           mc_vld = 1'b0;
  logic [2:0]   mc_cls;
  logic [W-1:0] mc_a, mc_b;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           lat;
  } vec_t;
  vec_t vecs[17];

  mult_div_seq_unit #(.PARALLELISM(W), .OPCODE_WIDTH(3), .CACHE_EN(CACHE_EN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opCode(opCode),
    .operand0(operand0), .operand1(operand1), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .div_by_zero(div_by_zero),
    .overflow_div(overflow_div), .overflow_mult(overflow_mult), .cache_hit(cache_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] cls_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 3'd0;
      3'd2:       return 3'd1;
      3'd3:       return 3'd2;
      3'd4, 3'd6: return 3'd4;
      default:    return 3'd5;
    endcase
  endfunction

  task automatic ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] r, output logic dz, output logic ovd, output logic ovm);
    longint p;
    longint unsigned pu;
    int sq;
    dz = 1'b0; ovd = 1'b0; ovm = 1'b0; r = '0;
    case (op)
      3'd0, 3'd1, 3'd2: begin
        if (op == 3'd2) p = longint'($signed(a)) * longint'(b);
        else            p = longint'($signed(a)) * longint'($signed(b));
        r   = (op == 3'd0) ? p[31:0] : p[63:32];
        ovm = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end
      3'd3: begin
        pu  = 64'(a) * 64'(b);
        r   = pu[63:32];
        ovm = pu[63:32] != 0;
      end
      default: begin
        if (a == 0) begin
          dz = 1'b1;
          r  = op[1] ? b : '1;
        end else if (!op[0] && a == 32'hFFFFFFFF && b == 32'h80000000) begin
          ovd = 1'b1;
          r   = op[1] ? 32'h0 : 32'h80000000;
        end else if (!op[0]) begin
          sq = op[1] ? (int'(b) % int'(a)) : (int'(b) / int'(a));
          r  = sq;
        end else begin
          r = op[1] ? (b % a) : (b / a);
        end
      end
    endcase
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL %s idle: in_ready stuck at %b expected 1", nm, in_ready);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef,
                       input int el);
    int cyc = 0;
    wait_idle(nm);
    opCode = op; operand0 = a; operand1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; opCode = 3'($urandom); operand0 = $urandom; operand1 = $urandom;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " latency"}, 64'(cyc), 64'(el));
    check({nm, " result"}, 64'(result), 64'(er));
    check({nm, " flags dz/ovd/ovm/hit"}, 64'({div_by_zero, overflow_div, overflow_mult, cache_hit}), 64'(ef));
    if (el != 1) begin
      mc_vld = 1'b1; mc_cls = cls_of(op); mc_a = a; mc_b = b;
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_model(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    logic [W-1:0] r;
    logic dz, ovd, ovm, hit;
    ref_model(op, a, b, r, dz, ovd, ovm);
    hit = (CACHE_EN != 0) && !dz && !ovd && mc_vld && mc_cls == cls_of(op) && mc_a == a && mc_b == b;
    issue(nm, op, a, b, r, {dz, ovd, ovm, hit}, (dz || ovd || hit) ? 1 : LAT_IT);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h80000000;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    bit           seen;
    int           cyc;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 4'b0000, LAT_IT};
    vecs[1]  = '{3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0001, 1};
    vecs[2]  = '{3'd3, 32'd7,        32'hFFFFFFFD, 32'h00000006, 4'b0010, LAT_IT};
    vecs[3]  = '{3'd4, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 4'b0100, 1};
    vecs[4]  = '{3'd6, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 4'b0100, 1};
    vecs[5]  = '{3'd5, 32'd0,        32'd100,      32'hFFFFFFFF, 4'b1000, 1};
    vecs[6]  = '{3'd7, 32'd0,        32'd100,      32'h00000064, 4'b1000, 1};
    vecs[7]  = '{3'd4, 32'd2,        32'hFFFFFFF9, 32'hFFFFFFFD, 4'b0000, LAT_IT};
    vecs[8]  = '{3'd6, 32'd2,        32'hFFFFFFF9, 32'hFFFFFFFF, 4'b0001, 1};
    vecs[9]  = '{3'd0, 32'h10000,    32'h10000,    32'h00000000, 4'b0010, LAT_IT};
    vecs[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, LAT_IT};
    vecs[11] = '{3'd5, 32'd7,        32'd100,      32'h0000000E, 4'b0000, LAT_IT};
    vecs[12] = '{3'd7, 32'd7,        32'd100,      32'h00000002, 4'b0001, 1};
    vecs[13] = '{3'd4, 32'hFFFFFFFD, 32'd20,       32'hFFFFFFFA, 4'b0000, LAT_IT};
    vecs[14] = '{3'd6, 32'hFFFFFFFD, 32'd20,       32'h00000002, 4'b0001, 1};
    vecs[15] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0010, LAT_IT};
    vecs[16] = '{3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0011, 1};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    opCode = '0; operand0 = '0; operand1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", 64'({in_ready, out_valid, busy, div_by_zero, overflow_div, overflow_mult,
                              cache_hit, result}), 64'({1'b1, 1'b0, 1'b0, 4'b0000, 32'h0}));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++)
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].lat);

    // Output held while the consumer stalls.
    out_ready = 1'b0;
    wait_idle("stall");
    opCode = 3'd5; operand0 = '0; operand1 = 32'h1234; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stall latency", 64'(cyc), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall hold %0d", k),
            64'({out_valid, in_ready, busy, div_by_zero, overflow_div, overflow_mult, cache_hit, result}),
            64'({1'b1, 1'b0, 1'b1, 4'b1000, 32'hFFFFFFFF}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall release", 64'({out_valid, in_ready, busy}), 64'(3'b010));

    // Flush in the middle of the iteration.
    wait_idle("flush");
    opCode = 3'd0; operand0 = 32'h1234; operand1 = 32'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("flush busy before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush idle", 64'({out_valid, in_ready, busy}), 64'(3'b010));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush no output", 64'(seen), 64'd0);
    issue_model("flush pair miss", 3'd1, 32'h1234, 32'h5678);

    // Reset in the middle of the iteration invalidates the cache.
    issue_model("rst pre", 3'd0, 32'd3, 32'd5);
    wait_idle("rst mid");
    opCode = 3'd3; operand0 = 32'd9; operand1 = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid state", 64'({in_ready, out_valid, busy, div_by_zero, overflow_div, overflow_mult,
                                cache_hit, result}), 64'({1'b1, 1'b0, 1'b0, 4'b0000, 32'h0}));
    mc_vld = 1'b0;
    issue_model("rst pair miss", 3'd1, 32'd3, 32'd5);

    ra = pick(); rb = pick();
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        ra = pick(); rb = pick();
      end
      issue_model($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
